// File: rtl/dmem_store_sink.sv
// Data-memory responder: posted-write store FIFO draining into a word RAM,
// forwarded core loads, a req/ack host read port and a to-host latch.
module dmem_store_sink #(
   parameter int          DEPTH_WORDS = 64,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] TOHOST_ADDR = 32'd100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        stall,
   input  logic        host_req,
   input  logic [31:0] host_addr,
   output logic        host_ack,
   output logic [31:0] host_data,
   output logic        done,
   output logic [31:0] done_value
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FullCnt = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0] CntOne  = (PW+1)'(1);
   localparam logic [PW-1:0] PtrOne = PW'(1);

   typedef enum logic {
      Idle,
      Ack
   } hostState_t;

   hostState_t state;

   logic [31:0]   mem      [DEPTH_WORDS];
   logic [AW-1:0] fifoIdx  [FIFO_DEPTH];
   logic [31:0]   fifoData [FIFO_DEPTH];

   logic [PW-1:0] headPtr;
   logic [PW-1:0] tailPtr;
   logic [PW:0]   count;

   logic [AW-1:0] coreIdx;
   logic [AW-1:0] hostIdx;
   logic          full;
   logic          push;
   logic          pop;
   logic          claim;
   logic [31:0]   coreFwd;
   logic [31:0]   hostFwd;
   logic [PW-1:0] slot;
   logic          unusedHost;

   assign coreIdx    = DataAdr[2 +: AW];
   assign hostIdx    = host_addr[2 +: AW];
   assign unusedHost = ^{host_addr[31:AW+2], host_addr[1:0]};

   assign full  = (count == FullCnt);
   assign push  = MemWrite && !full;
   assign claim = (state == Idle) && host_req;
   assign pop   = (count != '0) && !claim;
   assign stall = MemWrite && full;

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      coreFwd = mem[coreIdx];
      hostFwd = mem[hostIdx];
      slot    = headPtr;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         slot = headPtr + PW'(i);
         if (i < int'(count)) begin
            if (fifoIdx[slot] == coreIdx) begin
               coreFwd = fifoData[slot];
            end
            if (fifoIdx[slot] == hostIdx) begin
               hostFwd = fifoData[slot];
            end
         end
      end
   end

   assign ReadData = coreFwd;

   always_ff @(posedge clk) begin
      if (push) begin
         fifoIdx[tailPtr]  <= coreIdx;
         fifoData[tailPtr] <= WriteData;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) begin
         mem[fifoIdx[headPtr]] <= fifoData[headPtr];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            tailPtr <= tailPtr + PtrOne;
         end
         if (pop) begin
            headPtr <= headPtr + PtrOne;
         end
         unique case (1'b1)
            push && !pop: count <= count + CntOne;
            pop && !push: count <= count - CntOne;
            default:      count <= count;
         endcase
      end
   end

   // The accept edge also blocks drain, so host_data sees a stable FIFO view.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= Idle;
         host_ack  <= 1'b0;
         host_data <= '0;
      end else begin
         unique case (state)
            Idle: begin
               host_ack <= 1'b0;
               if (host_req) begin
                  host_data <= hostFwd;
                  host_ack  <= 1'b1;
                  state     <= Ack;
               end
            end
            Ack: begin
               host_ack <= 1'b0;
               state    <= Idle;
            end
            default: begin
               host_ack <= 1'b0;
               state    <= Idle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done       <= 1'b0;
         done_value <= '0;
      end else if (push && !done && DataAdr == TOHOST_ADDR) begin
         done       <= 1'b1;
         done_value <= WriteData;
      end
   end

endmodule

// File: tb/tb_dmem_store_sink.sv
// Scoreboarded bench for dmem_store_sink: host acks checked by a monitor,
// core-side outputs checked directly against hand-computed values.
module tb_dmem_store_sink;

   logic        clk;
   logic        rst;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        stall;
   logic        host_req;
   logic [31:0] host_addr;
   logic        host_ack;
   logic [31:0] host_data;
   logic        done;
   logic [31:0] done_value;

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   exp_t hq[$];
   int   total;
   int   bad;
   int   cycleCnt;

   dmem_store_sink dut (
      .clk(clk),
      .rst(rst),
      .MemWrite(MemWrite),
      .DataAdr(DataAdr),
      .WriteData(WriteData),
      .ReadData(ReadData),
      .stall(stall),
      .host_req(host_req),
      .host_addr(host_addr),
      .host_ack(host_ack),
      .host_data(host_data),
      .done(done),
      .done_value(done_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      MemWrite = 1'b0;
      host_req = 1'b0;
      repeat (n) step();
   endtask

   task automatic expAck(input logic [31:0] d, input int c);
      exp_t e;
      e.d = d;
      e.c = c;
      hq.push_back(e);
   endtask

   task automatic hostRead(input logic [31:0] a, input logic [31:0] d);
      host_req  = 1'b1;
      host_addr = a;
      expAck(d, cycleCnt + 1);
      step();
      host_req = 1'b0;
      step();
   endtask

   always @(negedge clk) begin
      if (host_ack === 1'b1) begin
         if (hq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack at cycle %0d want none",
                     cycleCnt);
         end else begin
            exp_t e;
            e = hq.pop_front();
            chk("host_data", host_data, e.d);
            chk("ack_cycle", cycleCnt, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [8:0] stallVec;
      logic       stallNow;
      int         idx;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      MemWrite  = 1'b0;
      DataAdr   = '0;
      WriteData = '0;
      host_req  = 1'b0;
      host_addr = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_hdata", host_data, 0);
      chk("rst_done", done, 0);
      chk("rst_dval", done_value, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      step();

      // Preload RAM
      MemWrite = 1'b1;
      DataAdr = 0;  WriteData = 32'hDEADBEEF; step();
      DataAdr = 40; WriteData = 32'h0000000A; step();
      DataAdr = 44; WriteData = 32'h0000000B; step();
      DataAdr = 48; WriteData = 32'h0000000C; step();
      idle(6);

      // Host handshake, request held
      host_req  = 1'b1;
      host_addr = 0;
      expAck(32'hDEADBEEF, cycleCnt + 1);
      expAck(32'hDEADBEEF, cycleCnt + 3);
      repeat (3) step();
      host_req = 1'b0;
      step();

      // Single store
      MemWrite = 1'b1; DataAdr = 96; WriteData = 7;
      step();
      MemWrite = 1'b0;
      @(negedge clk);
      chk("fwd_96", ReadData, 7);
      chk("done_early", done, 0);
      step();
      chk("ram_24", dut.mem[24], 7);

      // To-host
      MemWrite = 1'b1; DataAdr = 100; WriteData = 25;
      step();
      WriteData = 99;
      @(negedge clk);
      chk("done_set", done, 1);
      chk("done_val", done_value, 25);
      step();
      MemWrite = 1'b0;
      @(negedge clk);
      chk("done_keep", done_value, 25);
      chk("rd_100", ReadData, 99);
      idle(6);

      // Full FIFO while host reads claim every other edge
      stallVec  = 9'b0_1000_0000;
      idx       = 0;
      host_req  = 1'b1;
      host_addr = 96;
      for (int j = 0; j < 5; j++) expAck(7, cycleCnt + 1 + 2 * j);
      for (int t = 0; t < 9; t++) begin
         MemWrite  = 1'b1;
         DataAdr   = 32'(idx * 4);
         WriteData = 32'h100 + 32'(idx);
         @(negedge clk);
         chk($sformatf("stall_%0d", t), stall, stallVec[t]);
         stallNow = stall;
         step();
         if (!stallNow) idx++;
      end
      idle(8);
      for (int i = 0; i < 8; i++) begin
         DataAdr = 32'(i * 4);
         #1;
         chk($sformatf("full_rd_%0d", i), ReadData, 32'h100 + 32'(i));
      end
      hostRead(4, 32'h101);
      hostRead(28, 32'h107);
      idle(4);

      // Forwarding order
      host_req  = 1'b1;
      host_addr = 96;
      expAck(7, cycleCnt + 1);
      expAck(7, cycleCnt + 3);
      expAck(2, cycleCnt + 5);
      MemWrite = 1'b1; DataAdr = 12; WriteData = 32'h33;
      step();
      DataAdr = 8; WriteData = 1;
      step();
      WriteData = 2;
      step();
      MemWrite  = 1'b0;
      host_addr = 8;
      @(negedge clk);
      chk("fwd_young", ReadData, 2);
      step();
      step();
      host_req = 1'b0;
      idle(6);
      DataAdr = 12;
      #1;
      chk("rd_12", ReadData, 32'h33);

      // Reset mid-operation
      host_req  = 1'b1;
      host_addr = 96;
      expAck(7, cycleCnt + 1);
      MemWrite = 1'b1; DataAdr = 40; WriteData = 32'h111;
      step();
      DataAdr = 44; WriteData = 32'h222;
      step();
      DataAdr = 48; WriteData = 32'h333;
      step();
      #1 rst = 1'b0;
      #1;
      chk("mid_ack", host_ack, 0);
      chk("mid_hdata", host_data, 0);
      chk("mid_done", done, 0);
      chk("mid_dval", done_value, 0);
      chk("mid_stall", stall, 0);
      host_req = 1'b0;
      MemWrite = 1'b0;
      step();
      step();
      rst = 1'b1;
      idle(6);
      DataAdr = 40; #1; chk("rd_40", ReadData, 32'h111);
      DataAdr = 44; #1; chk("rd_44", ReadData, 32'hB);
      DataAdr = 48; #1; chk("rd_48", ReadData, 32'hC);
      hostRead(48, 32'hC);
      idle(4);

      chk("pending_acks", hq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
